// File: rtl/digtube_scan_checker.sv
// digtube_scan_checker
//   Monitors the scanned sel/seg lines of the 4-digit multiplexed seven-segment
//   driver. Each digit is captured once its sel/seg pair has been stable for
//   STABLE_CYC samples, decoded to a hex nibble, and the rebuilt 16-bit word is
//   compared with the word the driver was given.
//
//   Optional feature: define DIGTUBE_MISMATCH_CNT_EN to add O_err_cnt, a
//   saturating count of reported frames that mismatched or held a bad pattern.
//
// Ports
//   clkout_50M    in   1   system clock, 50 MHz
//   grst_n        in   1   asynchronous active-low reset
//   I_en          in   1   checker enable (shared with the display driver)
//   I_sel         in   4   digit select, sel[0] = bits[3:0] .. sel[3] = bits[15:12]
//   I_seg         in   8   segment lines, seg[0]=a .. seg[6]=g, seg[7]=dp
//   I_exp_data    in   16  word the driver is displaying
//   O_frame_valid out  1   one-cycle pulse, complete frame captured
//   O_frame_data  out  16  last reconstructed word, held
//   O_match       out  1   O_frame_data == I_exp_data at frame completion, held
//   O_seg_err     out  1   undecodable pattern seen in the reported frame, held
//   O_timeout     out  1   one-cycle pulse, scan stalled and frame aborted
//   O_err_cnt     out  16  (DIGTUBE_MISMATCH_CNT_EN only) bad-frame counter
module digtube_scan_checker #(
    parameter int unsigned STABLE_CYC     = 1000,
    parameter int unsigned TIMEOUT_CYC    = 2000000,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clkout_50M,
    input  logic        grst_n,
    input  logic        I_en,
    input  logic [3:0]  I_sel,
    input  logic [7:0]  I_seg,
    input  logic [15:0] I_exp_data,
    output logic        O_frame_valid,
    output logic [15:0] O_frame_data,
    output logic        O_match,
    output logic        O_seg_err,
    output logic        O_timeout
`ifdef DIGTUBE_MISMATCH_CNT_EN
    ,
    output logic [15:0] O_err_cnt
`endif
);

    localparam int unsigned SW = $clog2(STABLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYC);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    state_t        state_q, state_d;
    logic [11:0]   pair_s1, pair_s2;
    logic [11:0]   pair_n, prev_pair;
    logic [SW-1:0] stab_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [3:0]    flags_q;
    logic          pending_q;
    logic [15:0]   nib_q;
    logic [3:0]    sel_cur;
    logic          sel_onehot, capture;
    logic [3:0]    cap_sel;
    logic          dec_ok;
    logic [3:0]    dec_nib;
    logic          do_clear, take_cap, do_report, do_tmo;

    // Two-flop synchronizer on the raw scan lines.
    always_ff @(posedge clkout_50M or negedge grst_n) begin
        if (!grst_n) begin
            pair_s1 <= '0;
            pair_s2 <= '0;
        end else begin
            pair_s1 <= {I_sel, I_seg};
            pair_s2 <= pair_s1;
        end
    end

    // Normalise to active-high: sel bit 1 = digit enabled, seg bit 1 = lit.
    assign pair_n = pair_s2 ^ {{4{SEL_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};

    // Stability counter: holds (samples-equal - 1); it passes STAB_LAST only
    // once per stable run, which gives exactly one capture per pair.
    always_ff @(posedge clkout_50M or negedge grst_n) begin
        if (!grst_n) begin
            prev_pair  <= '0;
            stab_cnt_q <= '0;
        end else begin
            prev_pair <= pair_n;
            if (!I_en || (pair_n != prev_pair))
                stab_cnt_q <= '0;
            else if (stab_cnt_q != STAB_MAX)
                stab_cnt_q <= stab_cnt_q + SW'(1);
        end
    end

    assign sel_cur    = prev_pair[11:8];
    assign sel_onehot = (sel_cur != 4'd0) && ((sel_cur & (sel_cur - 4'd1)) == 4'd0);
    assign capture    = (stab_cnt_q == STAB_LAST) && sel_onehot;
    assign cap_sel    = capture ? sel_cur : 4'd0;

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (prev_pair[6:0])
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clkout_50M or negedge grst_n) begin
        if (!grst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_clear  = 1'b0;
        take_cap  = 1'b0;
        do_report = 1'b0;
        do_tmo    = 1'b0;
        if (!I_en) begin
            state_d  = IDLE;
            do_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = COLLECT;
                    do_clear = 1'b1;
                end
                COLLECT: begin
                    if (capture) begin
                        take_cap = 1'b1;
                        if (&(flags_q | cap_sel)) state_d = REPORT;
                    end else if (to_cnt_q == TO_LAST) begin
                        do_tmo = 1'b1;
                    end
                end
                REPORT: begin
                    // A capture landing here starts the next frame.
                    do_report = 1'b1;
                    take_cap  = capture;
                    state_d   = COLLECT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkout_50M or negedge grst_n) begin
        if (!grst_n) begin
            to_cnt_q      <= '0;
            flags_q       <= '0;
            pending_q     <= 1'b0;
            nib_q         <= '0;
            O_frame_valid <= 1'b0;
            O_frame_data  <= '0;
            O_match       <= 1'b0;
            O_seg_err     <= 1'b0;
            O_timeout     <= 1'b0;
`ifdef DIGTUBE_MISMATCH_CNT_EN
            O_err_cnt     <= '0;
`endif
        end else begin
            O_frame_valid <= 1'b0;
            O_timeout     <= 1'b0;
            if (take_cap) begin
                for (int unsigned i = 0; i < 4; i++)
                    if (cap_sel[i]) nib_q[i*4 +: 4] <= dec_nib;
            end
            if (do_clear) begin
                flags_q   <= '0;
                pending_q <= 1'b0;
                to_cnt_q  <= '0;
            end else if (do_report) begin
                O_frame_valid <= 1'b1;
                O_frame_data  <= nib_q;
                O_match       <= (nib_q == I_exp_data);
                O_seg_err     <= pending_q;
`ifdef DIGTUBE_MISMATCH_CNT_EN
                if (((nib_q != I_exp_data) || pending_q) && (O_err_cnt != 16'hFFFF))
                    O_err_cnt <= O_err_cnt + 16'd1;
`endif
                flags_q   <= cap_sel;
                pending_q <= take_cap && !dec_ok;
                to_cnt_q  <= '0;
            end else if (take_cap) begin
                flags_q   <= flags_q | cap_sel;
                pending_q <= pending_q | !dec_ok;
                to_cnt_q  <= '0;
            end else if (do_tmo) begin
                O_timeout <= 1'b1;
                flags_q   <= '0;
                pending_q <= 1'b0;
                to_cnt_q  <= '0;
            end else if ((state_q == COLLECT) && (to_cnt_q != TO_MAX)) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

endmodule
